proc_mem_arb: RTL and testbench

- Shares one single-ported, pipelined, 1-cycle-latency memory between the processor's instruction-fetch port and data port.
- Sits between the processor top level and the memory. Adds val/rdy request handshakes and valid-qualified responses.
- Data requests win conflicts by default. A starvation guard forces an instruction grant after a bounded number of consecutive denials.
- Provides a saturating conflict counter for performance tracing.

---
 rtl/proc_mem_arb_pkg.sv | 14 +
 rtl/proc_mem_arb_resp.sv | 61 ++++++
 rtl/proc_mem_arb.sv | 112 +++++++++++
 tb/tb_proc_mem_arb.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/proc_mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package proc_mem_arb_pkg;

  typedef enum logic [1:0] {
    OWNER_NONE   = 2'd0,
    OWNER_IMEM   = 2'd1,
    OWNER_DREAD  = 2'd2,
    OWNER_DWRITE = 2'd3
  } owner_e;

  localparam logic MEMREQ_READ  = 1'b0;
  localparam logic MEMREQ_WRITE = 1'b1;

endpackage

// File: rtl/proc_mem_arb_resp.sv
// Remembers who owns the in-flight memory access and steers the returning
// data to that requester one cycle later.
module proc_mem_arb_resp
  import proc_mem_arb_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        gnt_imem_i,
  input  logic        gnt_dmem_i,
  input  logic        dmem_type_i,
  input  logic [31:0] memresp_rdata_i,
  output logic        imemresp_val_o,
  output logic [31:0] imemresp_data_o,
  output logic        dmemresp_val_o,
  output logic [31:0] dmemresp_rdata_o
);

  owner_e owner_q, owner_d;

  always_comb begin
    owner_d = OWNER_NONE;
    if (gnt_imem_i) begin
      owner_d = OWNER_IMEM;
    end else if (gnt_dmem_i) begin
      owner_d = (dmem_type_i == MEMREQ_WRITE) ? OWNER_DWRITE : OWNER_DREAD;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      owner_q <= OWNER_NONE;
    end else begin
      owner_q <= owner_d;
    end
  end

  // Gating on rst_i drops a response whose request was accepted just before reset.
  always_comb begin
    imemresp_val_o   = 1'b0;
    imemresp_data_o  = '0;
    dmemresp_val_o   = 1'b0;
    dmemresp_rdata_o = '0;
    if (!rst_i) begin
      unique case (owner_q)
        OWNER_IMEM: begin
          imemresp_val_o  = 1'b1;
          imemresp_data_o = memresp_rdata_i;
        end
        OWNER_DREAD: begin
          dmemresp_val_o   = 1'b1;
          dmemresp_rdata_o = memresp_rdata_i;
        end
        OWNER_DWRITE: begin
          dmemresp_val_o = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/proc_mem_arb.sv
// Arbitrates one single-ported, 1-cycle-latency memory between the fetch and
// data ports; data wins conflicts unless fetch has been starved too long.
module proc_mem_arb
  import proc_mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 16
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             imemreq_val,
  output logic             imemreq_rdy,
  input  logic [31:0]      imemreq_addr,
  output logic             imemresp_val,
  output logic [31:0]      imemresp_data,
  input  logic             dmemreq_val,
  output logic             dmemreq_rdy,
  input  logic             dmemreq_type,
  input  logic [31:0]      dmemreq_addr,
  input  logic [31:0]      dmemreq_wdata,
  output logic             dmemresp_val,
  output logic [31:0]      dmemresp_rdata,
  output logic             memreq_val,
  output logic             memreq_type,
  output logic [31:0]      memreq_addr,
  output logic [31:0]      memreq_wdata,
  input  logic [31:0]      memresp_rdata,
  output logic [CNT_W-1:0] conflict_count
);

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  logic             gnt_imem;
  logic             gnt_dmem;
  logic             conflict;
  logic [3:0]       starve_q, starve_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign conflict = imemreq_val && dmemreq_val;

  always_comb begin
    gnt_imem = 1'b0;
    gnt_dmem = 1'b0;
    if (!rst) begin
      if (imemreq_val && (!dmemreq_val || (starve_q == STARVE_MAX))) begin
        gnt_imem = 1'b1;
      end else if (dmemreq_val) begin
        gnt_dmem = 1'b1;
      end
    end
  end

  assign imemreq_rdy = gnt_imem;
  assign dmemreq_rdy = gnt_dmem;

  always_comb begin
    memreq_val   = 1'b0;
    memreq_type  = MEMREQ_READ;
    memreq_addr  = '0;
    memreq_wdata = '0;
    if (gnt_imem) begin
      memreq_val  = 1'b1;
      memreq_addr = imemreq_addr;
    end else if (gnt_dmem) begin
      memreq_val   = 1'b1;
      memreq_type  = dmemreq_type;
      memreq_addr  = dmemreq_addr;
      memreq_wdata = dmemreq_wdata;
    end
  end

  // Denial run length of a waiting fetch; reaching STARVE_MAX forces the next grant.
  always_comb begin
    starve_d = '0;
    if (imemreq_val && !gnt_imem) begin
      starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + 4'd1;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (conflict && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= '0;
      cnt_q    <= '0;
    end else begin
      starve_q <= starve_d;
      cnt_q    <= cnt_d;
    end
  end

  assign conflict_count = cnt_q;

  proc_mem_arb_resp u_resp (
    .clk_i            (clk),
    .rst_i            (rst),
    .gnt_imem_i       (gnt_imem),
    .gnt_dmem_i       (gnt_dmem),
    .dmem_type_i      (dmemreq_type),
    .memresp_rdata_i  (memresp_rdata),
    .imemresp_val_o   (imemresp_val),
    .imemresp_data_o  (imemresp_data),
    .dmemresp_val_o   (dmemresp_val),
    .dmemresp_rdata_o (dmemresp_rdata)
  );

endmodule

// File: tb/tb_proc_mem_arb.sv
// Directed and randomized checks of proc_mem_arb against a transaction-level
// reference model of grants, memory contents and response ordering.
module tb_proc_mem_arb;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        ival, dval, dtype;
  logic [31:0] iaddr, daddr, dwdata;
  logic [31:0] memresp_rdata;

  logic        irdy, iresp_val, drdy, dresp_val, mval, mtype;
  logic [31:0] iresp_data, dresp_rdata, maddr, mwdata;
  logic [15:0] cc;

  logic        s_irdy, s_iresp_val, s_drdy, s_dresp_val, s_mval, s_mtype;
  logic [31:0] s_iresp_data, s_dresp_rdata, s_maddr, s_mwdata;
  logic [1:0]  s_cc;

  proc_mem_arb #(.STARVE_LIMIT(LIMIT), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .imemreq_val(ival), .imemreq_rdy(irdy), .imemreq_addr(iaddr),
    .imemresp_val(iresp_val), .imemresp_data(iresp_data),
    .dmemreq_val(dval), .dmemreq_rdy(drdy), .dmemreq_type(dtype),
    .dmemreq_addr(daddr), .dmemreq_wdata(dwdata),
    .dmemresp_val(dresp_val), .dmemresp_rdata(dresp_rdata),
    .memreq_val(mval), .memreq_type(mtype), .memreq_addr(maddr),
    .memreq_wdata(mwdata), .memresp_rdata(memresp_rdata),
    .conflict_count(cc)
  );

  proc_mem_arb #(.STARVE_LIMIT(LIMIT), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst),
    .imemreq_val(ival), .imemreq_rdy(s_irdy), .imemreq_addr(iaddr),
    .imemresp_val(s_iresp_val), .imemresp_data(s_iresp_data),
    .dmemreq_val(dval), .dmemreq_rdy(s_drdy), .dmemreq_type(dtype),
    .dmemreq_addr(daddr), .dmemreq_wdata(dwdata),
    .dmemresp_val(s_dresp_val), .dmemresp_rdata(s_dresp_rdata),
    .memreq_val(s_mval), .memreq_type(s_mtype), .memreq_addr(s_maddr),
    .memreq_wdata(s_mwdata), .memresp_rdata(memresp_rdata),
    .conflict_count(s_cc)
  );

  // Memory environment: single port, 1-cycle read latency, junk when no read.
  logic [31:0] mem_env [256];
  logic [31:0] ref_mem [256];
  logic        load;

  always @(posedge clk) begin
    if (load) begin
      mem_env <= ref_mem;
      memresp_rdata <= $urandom;
    end else if (mval && !mtype) begin
      memresp_rdata <= mem_env[maddr[9:2]];
    end else begin
      if (mval) mem_env[maddr[9:2]] <= mwdata;
      memresp_rdata <= $urandom;
    end
  end

  int          n_checks = 0;
  int          n_pass   = 0;
  int          wait_cnt;
  int          conflicts;
  int          pend;
  logic [31:0] pend_data;
  int          last_grant;
  logic        obs_irdy;
  logic        chk_en;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rnd_addr();
    return 32'($urandom_range(0, 15)) << 2;
  endfunction

  // One clock cycle: check outputs mid-cycle, then advance the model at the edge.
  task automatic cycle();
    int          grant;
    logic        ei, ed;
    logic [31:0] ea, ew;
    logic        et;
    @(negedge clk);
    grant = 0;
    if (!rst) begin
      if (ival && (!dval || wait_cnt == LIMIT)) grant = 1;
      else if (dval) grant = 2;
    end
    obs_irdy = irdy;
    if (chk_en) begin
      chk("imemreq_rdy", 32'(irdy), 32'(grant == 1));
      chk("dmemreq_rdy", 32'(drdy), 32'(grant == 2));
      chk("memreq_val",  32'(mval), 32'(grant != 0));
      ea = (grant == 1) ? iaddr : daddr;
      et = (grant == 1) ? 1'b0 : dtype;
      ew = (grant == 1) ? 32'h0 : dwdata;
      if (grant != 0) begin
        chk("memreq_addr",  maddr, ea);
        chk("memreq_type",  32'(mtype), 32'(et));
        chk("memreq_wdata", mwdata, ew);
      end
      ei = !rst && (pend == 1);
      ed = !rst && (pend == 2 || pend == 3);
      chk("imemresp_val", 32'(iresp_val), 32'(ei));
      chk("dmemresp_val", 32'(dresp_val), 32'(ed));
      if (ei || !ed) chk("imemresp_data", iresp_data, ei ? pend_data : 32'h0);
      if (ed || !ei) chk("dmemresp_rdata", dresp_rdata, (ed && pend == 2) ? pend_data : 32'h0);
      chk("conflict_count", 32'(cc), (conflicts > 65535) ? 32'd65535 : 32'(conflicts));
      chk("conflict_count_w2", 32'(s_cc), (conflicts > 3) ? 32'd3 : 32'(conflicts));
    end
    last_grant = grant;
    @(posedge clk);
    if (rst) begin
      wait_cnt  = 0;
      conflicts = 0;
      pend      = 0;
    end else begin
      if (ival && dval) conflicts++;
      wait_cnt = (ival && grant != 1) ? wait_cnt + 1 : 0;
      pend = 0;
      if (grant == 1) begin
        pend      = 1;
        pend_data = ref_mem[iaddr[9:2]];
      end else if (grant == 2) begin
        if (dtype) begin
          pend = 3;
          ref_mem[daddr[9:2]] = dwdata;
        end else begin
          pend      = 2;
          pend_data = ref_mem[daddr[9:2]];
        end
      end
    end
    #1;
  endtask

  logic [5:0] i_pat;

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = $urandom;
    ref_mem[8'h40] = 32'hDEADBEEF;
    wait_cnt = 0; conflicts = 0; pend = 0; pend_data = '0; last_grant = 0;
    obs_irdy = 1'b0; chk_en = 1'b0; load = 1'b1;
    rst = 1'b1; ival = 1'b1; dval = 1'b1; dtype = 1'b0;
    iaddr = 32'h0; daddr = 32'h200; dwdata = 32'h0;

    // Reset held 3 cycles with both requests valid
    cycle();
    load   = 1'b0;
    chk_en = 1'b1;
    cycle();
    cycle();

    // First cycle out of reset: conflict, data wins; then fetch alone
    rst = 1'b0;
    cycle();
    dval = 1'b0;
    cycle();
    ival = 1'b0;
    cycle();

    // Single fetch of 0x100
    ival = 1'b1; iaddr = 32'h100;
    cycle();
    ival = 1'b0;
    cycle();

    // Starvation: both held for 6 cycles
    ival = 1'b1; iaddr = 32'h4; dval = 1'b1; dtype = 1'b0; daddr = 32'h8;
    for (int k = 0; k < 6; k++) begin
      cycle();
      i_pat[k] = obs_irdy;
    end
    chk("starve_grant_pattern", 32'(i_pat), 32'b010000);
    chk("conflict_after_starve", 32'(cc), 32'd7);
    chk("conflict_saturated_w2", 32'(s_cc), 32'd3);
    ival = 1'b0; dval = 1'b0;
    cycle();

    // Write 0x40 then read it back
    dval = 1'b1; dtype = 1'b1; daddr = 32'h40; dwdata = 32'h12345678;
    #1;
    chk("write_memreq_type", 32'(mtype), 32'd1);
    chk("write_memreq_wdata", mwdata, 32'h12345678);
    cycle();
    dtype = 1'b0; dwdata = 32'h0;
    cycle();
    dval = 1'b0;
    #1;
    chk("read_after_write", dresp_rdata, 32'h12345678);
    cycle();

    // Reset the cycle after an accept: response is discarded
    ival = 1'b1; iaddr = 32'h10;
    cycle();
    ival = 1'b0; rst = 1'b1;
    #1;
    chk("resp_dropped_in_reset", 32'(iresp_val), 32'd0);
    cycle();
    rst = 1'b0;
    #1;
    chk("no_resp_after_reset", 32'({iresp_val, dresp_val}), 32'd0);
    cycle();

    // Randomized traffic honouring hold-until-accepted
    for (int c = 0; c < 400; c++) begin
      if (!ival || last_grant == 1) begin
        ival  = ($urandom_range(0, 3) != 0);
        iaddr = rnd_addr();
      end
      if (!dval || last_grant == 2) begin
        dval   = ($urandom_range(0, 3) != 0);
        dtype  = $urandom_range(0, 1) == 1;
        daddr  = rnd_addr();
        dwdata = $urandom;
      end
      rst = ($urandom_range(0, 49) == 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
